// File: rtl/io_port_bridge.sv
// ----------------------------------------------------------------------------
// io_port_bridge
//   Glue between the pipeline core's I/O pins and an external device.
//
//   TX path: core OUT writes (out_port qualified by out_en) are queued in a
//   DEPTH-entry circular FIFO. The FIFO drains to the device over a
//   valid/ready handshake (tx_data/tx_valid/tx_ready).
//
//   RX path: device words arrive over rx_data/rx_valid/rx_ready. An accepted
//   word is latched onto in_port. A one-cycle interrupt pulse follows, then a
//   HOLDOFF-cycle window in which no further word is taken and in_port is
//   stable.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   out_port, out_en    core write data / OUT strobe (one push per cycle)
//   tx_data, tx_valid   FIFO head to device, FIFO non-empty
//   tx_ready            device takes tx_data this cycle
//   rx_data, rx_valid   device word / offer
//   rx_ready            bridge can take rx_data
//   in_port             last accepted RX word, to core
//   interrupt           one-cycle interrupt request to core
//   tx_count            FIFO occupancy (0..DEPTH)
//   tx_ovf              sticky flag: a push was dropped on a full FIFO
// ----------------------------------------------------------------------------
module io_port_bridge #(
   parameter int W       = 16,
   parameter int DEPTH   = 4,
   parameter int HOLDOFF = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [W-1:0]             out_port,
   input  logic                     out_en,
   output logic [W-1:0]             tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic [W-1:0]             rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [W-1:0]             in_port,
   output logic                     interrupt,
   output logic [$clog2(DEPTH):0]   tx_count,
   output logic                     tx_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [HW-1:0] HLOAD = HW'(HOLDOFF - 1);

   // -------------------------------------------------------------------------
   // TX FIFO
   // -------------------------------------------------------------------------
   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    pop, push;

   assign tx_valid = (cnt_q != '0);
   assign pop      = tx_valid & tx_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
   assign push     = out_en & ((cnt_q != FULL) | pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
      if (out_en && !push)   ovf_d = 1'b1;
   end

   // Storage is reset too, so tx_data reads 0 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= out_port;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Registered head: no fall-through, stable while stalled.
   assign tx_data  = mem_q[rd_ptr_q];
   assign tx_count = cnt_q;
   assign tx_ovf   = ovf_q;

   // -------------------------------------------------------------------------
   // RX FSM
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_HOLD   = 2'd2
   } rx_state_t;

   rx_state_t     state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [W-1:0]  in_port_q, in_port_d;
   logic          irq_q, irq_d;
   logic          accept;

   assign rx_ready = (state_q == S_IDLE) & ~rst;
   assign accept   = rx_valid & rx_ready;

   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      in_port_d = in_port_q;
      irq_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               in_port_d = rx_data;
               irq_d     = 1'b1;      // pulse lands in the ASSERT cycle
               state_d   = S_ASSERT;
            end
         end
         S_ASSERT: begin
            hcnt_d  = HLOAD;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (hcnt_q == '0) state_d = S_IDLE;
            else              hcnt_d  = hcnt_q - HW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         hcnt_q    <= '0;
         in_port_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         in_port_q <= in_port_d;
         irq_q     <= irq_d;
      end
   end

   assign in_port   = in_port_q;
   assign interrupt = irq_q;

endmodule
